// File: rtl/key_event_queue.sv
// Key-press event FIFO fed by a held-key code; turns level codes into discrete press events.
// Define KEY_EVENT_QUEUE_REPEAT_EN to add typematic auto-repeat for a held key.
module key_event_queue #(
    parameter int DEPTH        = 8,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4:0]               keycode_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [4:0]               evt_code,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       prev_code_q, prev_code_d;
    logic [4:0]       evt_code_q, evt_code_d;
    logic             evt_valid_q, evt_valid_d;
    logic             overflow_q, overflow_d;

    logic [4:0] k;
    logic       press;
    logic       rpt_push;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       full;
    logic [4:0] head_d;

    always_comb begin
        k           = (keycode_in > 5'd14) ? 5'd0 : keycode_in;
        press       = (k != 5'd0) && (k != prev_code_q);
        prev_code_d = k;
    end

`ifdef KEY_EVENT_QUEUE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;

    // rpt_first selects the long initial delay until the first repeat has fired
    always_comb begin
        rpt_push    = 1'b0;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        if ((k == 5'd0) || press) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (rpt_cnt_q == (rpt_first_q ? DLY_LAST : RATE_LAST)) begin
            rpt_push    = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
        end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_push = 1'b0;
`endif

    always_comb begin
        pop      = evt_valid_q & evt_ready;
        push_req = press | rpt_push;
        full     = (count_q == CNT_W'(DEPTH));
        push_ok  = push_req && (!full || pop);

        wr_ptr_d = wr_ptr_q + (push_ok ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));

        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop)
            count_d = count_q - CNT_W'(1);

        if (push_req && !push_ok)
            overflow_d = 1'b1;
        else if (overflow_clr)
            overflow_d = 1'b0;
        else
            overflow_d = overflow_q;

        // The new head may be the entry being written this very cycle
        if (push_ok && (wr_ptr_q == rd_ptr_d))
            head_d = k;
        else
            head_d = mem_q[rd_ptr_d];

        evt_valid_d = (count_d != '0);
        evt_code_d  = evt_valid_d ? head_d : 5'd0;
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= k;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            prev_code_q <= 5'd0;
            evt_code_q  <= 5'd0;
            evt_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            prev_code_q <= prev_code_d;
            evt_code_q  <= evt_code_d;
            evt_valid_q <= evt_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule
